// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR+R) among N_PORTS requesters.
// Ports: clk/rst, s_ar*/s_r* per-requester, m_ar*/m_r* downstream, grant_id/busy/len_err status.
module axi_rd_arbiter #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 8,
  localparam int GW     = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        s_arvalid,
  output logic [N_PORTS-1:0]        s_arready,
  input  logic [N_PORTS*ADDR_W-1:0] s_araddr,
  input  logic [N_PORTS*LEN_W-1:0]  s_arlen,
  output logic [N_PORTS-1:0]        s_rvalid,
  input  logic [N_PORTS-1:0]        s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic                      s_rlast,
  output logic                      m_arvalid,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [LEN_W-1:0]          m_arlen,
  input  logic                      m_arready,
  input  logic                      m_rvalid,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_rlast,
  output logic                      m_rready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      len_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state, state_n;

  logic [GW-1:0]    g;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    pick;
  logic             found;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] exp_len;
  logic             acc;
  int               idx;

  assign grant_id = g;
  assign busy     = (state != IDLE);
  assign s_rdata  = m_rdata;
  assign s_rlast  = m_rlast;
  assign m_araddr = s_araddr[int'(g)*ADDR_W +: ADDR_W];
  assign m_arlen  = s_arlen[int'(g)*LEN_W +: LEN_W];

  // Scan from last_grant+1 so the previous winner has lowest priority.
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = (int'(last_grant) + i) % N_PORTS;
      if (!found && s_arvalid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_n   = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    acc       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) state_n = ADDR;
      end
      ADDR: begin
        m_arvalid    = 1'b1;
        s_arready[g] = m_arready;
        if (m_arready) state_n = DATA;
      end
      DATA: begin
        s_rvalid[g] = m_rvalid;
        m_rready    = s_rready[g];
        acc         = m_rvalid & s_rready[g];
        if (acc && m_rlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= GW'(N_PORTS - 1);
      beat_cnt   <= '0;
      exp_len    <= '0;
      len_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        g        <= pick;
        beat_cnt <= '0;
        exp_len  <= s_arlen[int'(pick)*LEN_W +: LEN_W];
      end
      if (acc) begin
        beat_cnt <= beat_cnt + 1'b1;
        // rlast must coincide exactly with the beat at index exp_len.
        if (m_rlast != (beat_cnt == exp_len)) len_err <= 1'b1;
        if (m_rlast) last_grant <= g;
      end
    end
  end

endmodule
